delay_mod_lfo: RTL
==================

# delay_mod_lfo

Low-frequency modulation source that drives the `mod_val` input of `delay_core` for chorus, vibrato and flanger effects. A phase accumulator advances once per audio-sample strobe. Its phase is shaped into a triangle or sawtooth waveform, scaled by a depth in samples, and presented as a signed 16-bit delay offset with a one-cycle valid pulse. The block sits in the same clock domain as `delay_core`, and both share the same `en` sample strobe.

## Interface
- `PHASE_W`, 24: phase accumulator width; the top 16 bits index the waveform.
- `DEPTH_W`, 8: depth width; peak excursion is in samples.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: sample strobe, the same strobe `delay_core` uses. Advances the LFO one step.
- `sync` in 1: phase reset; usable on any cycle.
- `rate` in PHASE_W: phase increment per strobe, unsigned.
- `depth` in DEPTH_W: peak modulation in samples, unsigned.
- `shape` in 1: 0 = triangle, 1 = sawtooth.
- `mod_val` out 16: signed delay offset. Connects to `delay_core.mod_val`.
- `mod_valid` out 1: one-cycle pulse; `mod_val` updated this cycle.

## Operation
- **Phase stage (S0):**
  - On a `clk` edge with `sync=1`: `phase <= 0`. `sync` has priority over `en`.
  - Else on `en=1`: `phase <= phase + rate`, wrapping modulo 2^PHASE_W.
  - Else `phase` holds.
  - An S0 step (`en=1`, with or without `sync`) launches one pipeline token.
- **Waveform stage (S1):** `p = phase[PHASE_W-1 -: 16]`, unsigned.
  - Triangle: `t = p[15] ? ~p[14:0] : p[14:0]`; `wave = 2*t - 32767`. Range −32767..+32767. Minimum at phase 0, maximum at half phase.
  - Sawtooth: `wave = p - 32768`, clamped to −32767 at the low end.
  - `shape` is sampled in S1.
- **Scale stage (S2):** `mod_val <= (wave * $signed({1'b0,depth}) + 16384) >>> 15`.
  - Round half up, arithmetic shift, then truncate to 16 bits.
  - Full-scale `wave` yields exactly ±`depth`.
  - `depth` is sampled in S2.
- **Arithmetic:** the product is 17×9 signed. Keep at least 26 bits before the shift. No overflow is possible for DEPTH_W ≤ 15.
- **Clamping:** `mod_val` is not clamped against `base_delay`. `delay_core` clamps the sum.
- `rate=0` gives a constant output for the current phase.
- When `en` is low, `mod_val` holds and `mod_valid` stays 0.

## Timing
- **Reset values:** `phase=0`, pipeline registers 0, `mod_val=0`, `mod_valid=0`. Reset applies asynchronously at any point, including mid-pipeline. Pending tokens are discarded.
- **Latency:**
  - `en` high at edge k updates `phase` at k.
  - S1 registers at k+1.
  - `mod_val` and `mod_valid=1` register at k+2.
  - `mod_valid` drops at k+3 unless another token follows.
- **Throughput:** one token per cycle. `en` may be high continuously.
- **Back-to-back:** consecutive strobes produce consecutive `mod_valid` pulses in order.
- **`sync` without `en`:** zeroes `phase` only. No token is launched, and `mod_val` is unchanged until the next strobe.
- **`sync` with `en` at the same edge:** `phase` becomes 0, not `rate`. The token carries phase 0.
- **Tokens in flight:** a `sync` or a `rate` change does not alter tokens already in flight.

## Configuration
- **`DELAY_LFO_SLEW_EN` defined:** S2 computes the target as above. On each token, `mod_val` moves toward the target by at most 1 (±1 or 0). This removes jumps at sawtooth wrap, on `sync`, and on `depth` changes. Latency is unchanged. Reset value is 0, so the output ramps from 0 after reset.
- **Not defined:** `mod_val` equals the target directly, and no slew logic is synthesized.

## Test plan
1. **Reset:** assert `rst_n=0` mid-run with `en=1` → `mod_val=0` and `mod_valid=0` asynchronously. After release, the first `mod_valid` appears 2 cycles after the first `en`.
2. **Triangle:**
   - Setup: `rate=0x040000`, `depth=50`, `shape=0`, `en` every cycle.
   - Outputs for steps n=0,16,32,48,64 (phase after n strobes): −50, 0, +50, 0, −50.
   - Period is 64 tokens. Each `mod_valid` arrives 2 cycles after its `en`.
3. **Sawtooth:**
   - Setup: same rate and depth, `shape=1`.
   - n=0 → −50, n=32 → 0, n=63 → +48, n=64 → −50 (wrap jump).
4. **`sync`:**
   - `sync` with `en` at n=20 → that token outputs −50 (triangle at phase 0). The next step equals the n=1 value.
   - `sync` alone → no `mod_valid` pulse.
5. **Depth and gating:**
   - `depth=0` → `mod_val=0` on every token.
   - Drop `en` for 10 cycles → `mod_val` holds and `mod_valid=0`.
   - Resume → the sequence continues from the held phase.
6. **`DELAY_LFO_SLEW_EN`:** run the sawtooth case with the macro defined. At wrap, `mod_val` steps +48, +47, … one per token. It never changes by more than 1 per token and reaches the rising target within 98 tokens.

Source files
------------

// File: rtl/delay_mod_lfo.sv
// delay_mod_lfo: low-frequency modulation source for delay_core.mod_val.
// A phase accumulator steps once per sample strobe. Its phase is shaped into
// a triangle or sawtooth wave and scaled by a depth given in samples.
// Pipeline: S0 phase, S1 waveform, S2 scale. A strobe at edge k gives
// mod_valid at edge k+2.
// Optional macro DELAY_LFO_SLEW_EN limits each change of mod_val to +/-1
// per token.
module delay_mod_lfo #(
  parameter int PHASE_W = 24,
  parameter int DEPTH_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync,
  input  logic [PHASE_W-1:0]  rate,
  input  logic [DEPTH_W-1:0]  depth,
  input  logic                shape,
  output logic signed [15:0]  mod_val,
  output logic                mod_valid
);

  // The 17x(DEPTH_W+1) signed product, plus one bit of headroom for the rounding add.
  localparam int PROD_W = 17 + DEPTH_W + 2;

  logic [PHASE_W-1:0]       phase;
  logic                     v0;
  logic                     v1;
  logic [15:0]              p;
  logic [14:0]              tri_t;
  logic signed [16:0]       wave_d;
  logic signed [16:0]       wave_q;
  logic signed [DEPTH_W:0]  depth_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sum;
  logic signed [PROD_W-1:0] shifted;
  logic signed [15:0]       target;

  // S0: phase accumulator. sync wins over en. Each strobe launches a token.
  // NOTE: state registers use non-blocking (<=) so every stage samples the
  // pre-edge value of the stage before it. That keeps tokens in flight
  // unaffected by a later sync or rate change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      v0    <= 1'b0;
    end else begin
      v0 <= en;
      if (sync) begin
        phase <= '0;
      end else if (en) begin
        phase <= phase + rate;
      end
    end
  end

  // S1 combinational: shape the top 16 phase bits into a signed wave.
  // NOTE: every always_comb output gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    p      = phase[PHASE_W-1 -: 16];
    tri_t  = '0;
    wave_d = '0;
    if (!shape) begin
      tri_t  = p[15] ? ~p[14:0] : p[14:0];
      wave_d = $signed({1'b0, tri_t, 1'b0}) - 17'sd32767;
    end else begin
      wave_d = $signed({1'b0, p}) - 17'sd32768;
      if (wave_d == -17'sd32768) begin
        wave_d = -17'sd32767;
      end
    end
  end

  // S1 register: capture the wave for the token that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      wave_q <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        wave_q <= wave_d;
      end
    end
  end

  // S2 combinational: scale by depth, round half up, then shift arithmetically.
  always_comb begin
    depth_s = $signed({1'b0, depth});
    prod    = PROD_W'(wave_q) * PROD_W'(depth_s);
    sum     = prod + PROD_W'(16384);
    shifted = sum >>> 15;
    target  = shifted[15:0];
  end

  // S2 register: update the output and raise the valid pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_val   <= '0;
      mod_valid <= 1'b0;
    end else begin
      mod_valid <= v1;
      if (v1) begin
`ifdef DELAY_LFO_SLEW_EN
        if (target > mod_val) begin
          mod_val <= mod_val + 16'sd1;
        end else if (target < mod_val) begin
          mod_val <= mod_val - 16'sd1;
        end
`else
        mod_val <= target;
`endif
      end
    end
  end

endmodule
